// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read data RAM.
// Registers one command per cycle and steers the returning read data to its owner.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int CPU_PRIORITY = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_wEn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut
);

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_any_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;

    // Read-return tracking: stage 1 = command at the RAM, stage 2 = data on mem_dataOut.
    logic              r_s1_valid;
    logic              r_s1_owner;
    logic              r_s2_valid;
    logic              r_s2_owner;

    generate
        if (CPU_PRIORITY != 0) begin : g_fixed
            localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

            logic [3:0] r_wait_cnt;
            logic       w_b_forced;

            assign w_b_forced = (r_wait_cnt == LP_MAX_WAIT);
            assign w_b_gnt    = reset && b_req && (!a_req || w_b_forced);
            assign w_a_gnt    = reset && a_req && !w_b_gnt;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_wait_cnt <= 4'd0;
                end else if (w_b_gnt) begin
                    r_wait_cnt <= 4'd0;
                end else if (b_req && (r_wait_cnt != LP_MAX_WAIT)) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end
        end else begin : g_rr
            localparam logic LAST_A = 1'b0;
            localparam logic LAST_B = 1'b1;

            logic r_last;

            // On a tie the side that did not win most recently goes next.
            assign w_a_gnt = reset && a_req && (!b_req || (r_last == LAST_B));
            assign w_b_gnt = reset && b_req && !w_a_gnt;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_last <= LAST_B;
                end else if (w_a_gnt) begin
                    r_last <= LAST_A;
                end else if (w_b_gnt) begin
                    r_last <= LAST_B;
                end
            end
        end
    endgenerate

    assign w_any_gnt   = w_a_gnt | w_b_gnt;
    assign w_sel_we    = w_b_gnt ? b_we    : a_we;
    assign w_sel_addr  = w_b_gnt ? b_addr  : a_addr;
    assign w_sel_wdata = w_b_gnt ? b_wdata : a_wdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mem_wen  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_owner <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_owner <= 1'b0;
        end else begin
            r_mem_wen <= w_any_gnt & w_sel_we;
            if (w_any_gnt) begin
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_we ? w_sel_wdata : '0;
            end
            r_s1_valid <= w_any_gnt & ~w_sel_we;
            r_s1_owner <= w_b_gnt;
            r_s2_valid <= r_s1_valid;
            r_s2_owner <= r_s1_owner;
        end
    end

    assign a_gnt      = w_a_gnt;
    assign b_gnt      = w_b_gnt;
    assign mem_wEn    = r_mem_wen;
    assign mem_addr   = r_mem_addr;
    assign mem_dataIn = r_mem_din;

    assign a_rvalid = r_s2_valid & ~r_s2_owner;
    assign b_rvalid = r_s2_valid &  r_s2_owner;
    assign a_rdata  = a_rvalid ? mem_dataOut : '0;
    assign b_rdata  = b_rvalid ? mem_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a fixed-priority and a round-robin instance, each with a
// behavioural RAM, checked by directed grant checks plus a read-return scoreboard.
module tb_dmem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic rst_q  = 1'b1;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    // ---------------- fixed-priority instance (F) ----------------
    logic        fa_req = 0, fa_we = 0, fb_req = 0, fb_we = 0;
    logic [11:0] fa_addr = 0, fb_addr = 0;
    logic [31:0] fa_wdata = 0, fb_wdata = 0;
    logic        fa_gnt, fa_rvalid, fb_gnt, fb_rvalid, fmem_wEn;
    logic [31:0] fa_rdata, fb_rdata, fmem_dataIn, fmem_dataOut;
    logic [11:0] fmem_addr;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .CPU_PRIORITY(1), .MAX_WAIT(4)) u_fix (
        .clock(clock), .reset(reset),
        .a_req(fa_req), .a_we(fa_we), .a_addr(fa_addr), .a_wdata(fa_wdata),
        .a_gnt(fa_gnt), .a_rvalid(fa_rvalid), .a_rdata(fa_rdata),
        .b_req(fb_req), .b_we(fb_we), .b_addr(fb_addr), .b_wdata(fb_wdata),
        .b_gnt(fb_gnt), .b_rvalid(fb_rvalid), .b_rdata(fb_rdata),
        .mem_wEn(fmem_wEn), .mem_addr(fmem_addr), .mem_dataIn(fmem_dataIn),
        .mem_dataOut(fmem_dataOut)
    );

    // ---------------- round-robin instance (R) ----------------
    logic        ra_req = 0, ra_we = 0, rb_req = 0, rb_we = 0;
    logic [11:0] ra_addr = 0, rb_addr = 0;
    logic [31:0] ra_wdata = 0, rb_wdata = 0;
    logic        ra_gnt, ra_rvalid, rb_gnt, rb_rvalid, rmem_wEn;
    logic [31:0] ra_rdata, rb_rdata, rmem_dataIn, rmem_dataOut;
    logic [11:0] rmem_addr;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .CPU_PRIORITY(0), .MAX_WAIT(4)) u_rr (
        .clock(clock), .reset(reset),
        .a_req(ra_req), .a_we(ra_we), .a_addr(ra_addr), .a_wdata(ra_wdata),
        .a_gnt(ra_gnt), .a_rvalid(ra_rvalid), .a_rdata(ra_rdata),
        .b_req(rb_req), .b_we(rb_we), .b_addr(rb_addr), .b_wdata(rb_wdata),
        .b_gnt(rb_gnt), .b_rvalid(rb_rvalid), .b_rdata(rb_rdata),
        .mem_wEn(rmem_wEn), .mem_addr(rmem_addr), .mem_dataIn(rmem_dataIn),
        .mem_dataOut(rmem_dataOut)
    );

    // Synchronous-read RAMs; addresses 1 and 2 are (re)loaded while reset is low.
    logic [31:0] ram_f [4096];
    logic [31:0] ram_r [4096];

    always @(posedge clock) begin
        if (!reset) begin
            ram_f[1] <= 32'h11111111;
            ram_f[2] <= 32'h22222222;
        end else if (fmem_wEn) begin
            ram_f[fmem_addr] <= fmem_dataIn;
        end
        fmem_dataOut <= ram_f[fmem_addr];
    end

    always @(posedge clock) begin
        if (!reset) begin
            ram_r[1] <= 32'h11111111;
            ram_r[2] <= 32'h22222222;
        end else if (rmem_wEn) begin
            ram_r[rmem_addr] <= rmem_dataIn;
        end
        rmem_dataOut <= ram_r[rmem_addr];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        owner;   // 0 = A, 1 = B
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [2][$];
    logic [31:0] sh  [2][4096];

    task automatic mon(input int k,
                       input logic ar, input logic ag, input logic awe,
                       input logic [11:0] aad, input logic [31:0] awd,
                       input logic br, input logic bg, input logic bwe,
                       input logic [11:0] bad, input logic [31:0] bwd,
                       input logic arv, input logic [31:0] ard,
                       input logic brv, input logic [31:0] brd,
                       input logic wen, input logic [11:0] madr, input logic [31:0] mdin);
        exp_t e;
        chk($sformatf("i%0d_gnt_onehot", k), {31'b0, ag & bg}, 32'd0);
        chk($sformatf("i%0d_a_gnt_no_req", k), {31'b0, ag & ~ar}, 32'd0);
        chk($sformatf("i%0d_b_gnt_no_req", k), {31'b0, bg & ~br}, 32'd0);
        if (!reset) begin
            sbq[k].delete();
            sh[k][1] = 32'h11111111;
            sh[k][2] = 32'h22222222;
            chk($sformatf("i%0d_rst_a_gnt", k), {31'b0, ag}, 32'd0);
            chk($sformatf("i%0d_rst_b_gnt", k), {31'b0, bg}, 32'd0);
        end
        if (!rst_q) begin
            chk($sformatf("i%0d_rst_wen", k), {31'b0, wen}, 32'd0);
            chk($sformatf("i%0d_rst_addr", k), {20'b0, madr}, 32'd0);
            chk($sformatf("i%0d_rst_din", k), mdin, 32'd0);
            chk($sformatf("i%0d_rst_a_rvalid", k), {31'b0, arv}, 32'd0);
            chk($sformatf("i%0d_rst_b_rvalid", k), {31'b0, brv}, 32'd0);
            chk($sformatf("i%0d_rst_a_rdata", k), ard, 32'd0);
            chk($sformatf("i%0d_rst_b_rdata", k), brd, 32'd0);
        end else if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
            e = sbq[k].pop_front();
            $display("i%0d cycle %0d: read return owner=%s data=%h", k, cyc, e.owner ? "B" : "A", e.data);
            chk($sformatf("i%0d_a_rvalid", k), {31'b0, arv}, {31'b0, ~e.owner});
            chk($sformatf("i%0d_b_rvalid", k), {31'b0, brv}, {31'b0, e.owner});
            chk($sformatf("i%0d_rdata", k), e.owner ? brd : ard, e.data);
            chk($sformatf("i%0d_other_rdata", k), e.owner ? ard : brd, 32'd0);
        end else begin
            chk($sformatf("i%0d_a_rvalid_unexp", k), {31'b0, arv}, 32'd0);
            chk($sformatf("i%0d_b_rvalid_unexp", k), {31'b0, brv}, 32'd0);
        end
        if (reset) begin
            if (ag && ar) begin
                if (awe) sh[k][aad] = awd;
                else sbq[k].push_back('{owner: 1'b0, data: sh[k][aad], due: cyc + 2});
            end
            if (bg && br) begin
                if (bwe) sh[k][bad] = bwd;
                else sbq[k].push_back('{owner: 1'b1, data: sh[k][bad], due: cyc + 2});
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, fa_req, fa_gnt, fa_we, fa_addr, fa_wdata, fb_req, fb_gnt, fb_we, fb_addr, fb_wdata,
            fa_rvalid, fa_rdata, fb_rvalid, fb_rdata, fmem_wEn, fmem_addr, fmem_dataIn);
        mon(1, ra_req, ra_gnt, ra_we, ra_addr, ra_wdata, rb_req, rb_gnt, rb_we, rb_addr, rb_wdata,
            ra_rvalid, ra_rdata, rb_rvalid, rb_rdata, rmem_wEn, rmem_addr, rmem_dataIn);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        fa_req = 1; fa_addr = 12'h001; fb_req = 1; fb_addr = 12'h002;
        ra_req = 1; ra_addr = 12'h001; rb_req = 1; rb_addr = 12'h002;
        repeat (3) @(posedge clock);
        #1 reset = 1;

        // Continuous contention: fixed gives A,A,A,A,B; round-robin alternates from A.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            $display("cycle %0d: fixed a=%b b=%b  rr a=%b b=%b", cyc, fa_gnt, fb_gnt, ra_gnt, rb_gnt);
            chk($sformatf("fix_a_gnt[%0d]", i), {31'b0, fa_gnt}, {31'b0, (i % 5) != 4});
            chk($sformatf("fix_b_gnt[%0d]", i), {31'b0, fb_gnt}, {31'b0, (i % 5) == 4});
            chk($sformatf("rr_a_gnt[%0d]", i), {31'b0, ra_gnt}, {31'b0, (i % 2) == 0});
            chk($sformatf("rr_b_gnt[%0d]", i), {31'b0, rb_gnt}, {31'b0, (i % 2) == 1});
        end
        step();

        // Single requester B is granted every cycle in both modes.
        fa_req = 0; ra_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            $display("cycle %0d: b only, fixed b=%b rr b=%b", cyc, fb_gnt, rb_gnt);
            chk($sformatf("fix_b_only[%0d]", i), {31'b0, fb_gnt}, 32'd1);
            chk($sformatf("rr_b_only[%0d]", i), {31'b0, rb_gnt}, 32'd1);
        end
        step();
        fb_req = 0; rb_req = 0;
        repeat (3) step();

        // Write then read-after-write on A.
        fa_req = 1; fa_we = 1; fa_addr = 12'h010; fa_wdata = 32'hDEADBEEF;
        @(negedge clock);
        $display("cycle %0d: A write 010 gnt=%b", cyc, fa_gnt);
        chk("wr_gnt", {31'b0, fa_gnt}, 32'd1);
        step();
        fa_we = 0;
        @(negedge clock);
        $display("cycle %0d: A read 010 gnt=%b wen=%b", cyc, fa_gnt, fmem_wEn);
        chk("rd_gnt", {31'b0, fa_gnt}, 32'd1);
        chk("wen_hi", {31'b0, fmem_wEn}, 32'd1);
        chk("wr_addr", {20'b0, fmem_addr}, 32'h010);
        chk("wr_din", fmem_dataIn, 32'hDEADBEEF);
        step();
        fa_req = 0;
        @(negedge clock);
        chk("wen_lo", {31'b0, fmem_wEn}, 32'd0);
        chk("rd_addr", {20'b0, fmem_addr}, 32'h010);
        chk("rd_din_zero", fmem_dataIn, 32'd0);
        step();
        @(negedge clock);
        $display("cycle %0d: A rvalid=%b rdata=%h", cyc, fa_rvalid, fa_rdata);
        chk("raw_rvalid", {31'b0, fa_rvalid}, 32'd1);
        chk("raw_rdata", fa_rdata, 32'hDEADBEEF);
        chk("raw_b_rvalid", {31'b0, fb_rvalid}, 32'd0);
        step();

        // A reads 0x001, B reads 0x002 on consecutive cycles.
        fa_req = 1; fa_addr = 12'h001;
        @(negedge clock);
        chk("x_a_gnt", {31'b0, fa_gnt}, 32'd1);
        step();
        fa_req = 0; fb_req = 1; fb_we = 0; fb_addr = 12'h002;
        @(negedge clock);
        chk("x_b_gnt", {31'b0, fb_gnt}, 32'd1);
        step();
        fb_req = 0;
        @(negedge clock);
        $display("cycle %0d: a_rvalid=%b a_rdata=%h b_rvalid=%b", cyc, fa_rvalid, fa_rdata, fb_rvalid);
        chk("x_a_rvalid", {31'b0, fa_rvalid}, 32'd1);
        chk("x_a_rdata", fa_rdata, 32'h11111111);
        chk("x_b_quiet", {31'b0, fb_rvalid}, 32'd0);
        step();
        @(negedge clock);
        $display("cycle %0d: b_rvalid=%b b_rdata=%h a_rvalid=%b", cyc, fb_rvalid, fb_rdata, fa_rvalid);
        chk("x_b_rvalid", {31'b0, fb_rvalid}, 32'd1);
        chk("x_b_rdata", fb_rdata, 32'h22222222);
        chk("x_a_quiet", {31'b0, fa_rvalid}, 32'd0);
        step();

        // Reset asserted the edge after an A read is granted: the read is dropped.
        fa_req = 1; fa_addr = 12'h002;
        @(negedge clock);
        chk("mid_rst_gnt", {31'b0, fa_gnt}, 32'd1);
        step();
        fa_req = 0; reset = 0;
        @(negedge clock);
        step();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            $display("cycle %0d: after mid reset a_rvalid=%b mem_addr=%h", cyc, fa_rvalid, fmem_addr);
            chk($sformatf("mid_rst_a_rvalid[%0d]", i), {31'b0, fa_rvalid}, 32'd0);
            chk($sformatf("mid_rst_mem_addr[%0d]", i), {20'b0, fmem_addr}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data RAM (12-bit word address, 32-bit data, synchronous read) between the processor (port A) and a peripheral requester (port B), e.g. game/VGA logic. It sits between the processor's dmem interface and the `RAM` instance in the top-level wrapper. Each cycle it issues at most one access to the RAM, registers the command, and routes the read data back to the requester that issued the read.

## Interface
- `ADDR_W`, 12: word-address width.
- `DATA_W`, 32: data width.
- `CPU_PRIORITY`, 1: 1 = fixed priority to A with a starvation guard for B; 0 = round-robin.
- `MAX_WAIT`, 4: used only when `CPU_PRIORITY=1`; number of consecutive denied cycles after which B is forced to win (range 1..15).
- `clock` in 1: single clock; everything updates on the rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `a_req` in 1: A requests an access.
- `a_we` in 1: 1 = write, 0 = read.
- `a_addr` in ADDR_W: word address.
- `a_wdata` in DATA_W: write data.
- `a_gnt` out 1: A's request is accepted this cycle.
- `a_rvalid` out 1: `a_rdata` holds A's read result.
- `a_rdata` out DATA_W: read data for A.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the A-port signals, for B.
- `mem_wEn` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_dataIn` out DATA_W: RAM write data.
- `mem_dataOut` in DATA_W: RAM read data, valid the cycle after the RAM samples the address.

## Operation
- Handshake:
  - An access transfers on a rising edge where `x_req && x_gnt`.
  - The requester holds `req`, `we`, `addr` and `wdata` stable until it is granted.
  - `x_gnt` is combinational from `x_req` and the arbitration state. It is never high without `x_req`.
  - At most one of `a_gnt` and `b_gnt` is high in any cycle.
- Fixed mode (`CPU_PRIORITY=1`):
  - A wins when `a_req` is high, unless `wait_cnt == MAX_WAIT`.
  - `wait_cnt` (4-bit) increments each cycle with `b_req && !b_gnt`, saturates at `MAX_WAIT`, and clears on a B grant.
  - When `wait_cnt == MAX_WAIT` and `b_req` is high, B wins.
  - If only one side requests, that side wins.
- Round-robin mode (`CPU_PRIORITY=0`):
  - A `last` bit records the most recent winner.
  - On a tie, the side other than `last` wins. With one requester, that side wins.
  - `last` updates on every grant.
- Command register:
  - On a granted edge: `mem_addr <= winner addr`, `mem_wEn <= winner we`, `mem_dataIn <= winner we ? wdata : 0`.
  - With no grant: `mem_wEn <= 0`. `mem_addr` and `mem_dataIn` hold their values.
- Read return:
  - A 2-stage owner/valid shift register tracks reads (stage 1 = command issued, stage 2 = data available).
  - Writes do not enter it.
  - In stage 2, `x_rvalid = 1` for the owner and `x_rdata = mem_dataOut`.
  - The non-owner's `rdata` is 0.
- Back-to-back grants are allowed every cycle; the return pipeline handles interleaved A/B reads in order.
- Simultaneous A write and B read (or write) to the same address: only one is granted that cycle, and the loser is serviced later. Ordering is resolved purely by grant order.

## Timing
- A read granted at the edge ending cycle N:
  - `mem_addr` valid in cycle N+1.
  - RAM samples at the end of cycle N+1.
  - `x_rvalid` and `x_rdata` are high/valid for exactly cycle N+2.
- Read latency from grant is 2 cycles; throughput is 1 access per cycle.
- A write granted in cycle N: `mem_wEn` is high for exactly cycle N+1, and memory is updated at the end of N+1.
- A read to the same address granted in the cycle after a write returns the new data.
- Reset (`reset==0` at an edge):
  - `mem_wEn=0`, `mem_addr=0`, `mem_dataIn=0`.
  - Return pipeline cleared, so `a_rvalid=b_rvalid=0` and `a_rdata=b_rdata=0`.
  - `wait_cnt=0`; `last=B`, so A wins the first tie.
  - `a_gnt=b_gnt=0` while `reset` is low.
- Reset mid-operation: reads in flight are dropped, and no `rvalid` appears after reset deasserts for commands issued before it.

## Test plan
- Hold `reset` low for 3 cycles with `a_req=b_req=1` -> `a_gnt=b_gnt=0`, `mem_wEn=0`, both `rvalid` 0. First tie after release grants A.
- A writes 0xDEADBEEF to 0x010, then reads 0x010 the next cycle -> `mem_wEn` high for 1 cycle; `a_rvalid` high 2 cycles after the read grant with `a_rdata=0xDEADBEEF`; `b_rvalid` stays 0.
- `CPU_PRIORITY=1`, `MAX_WAIT=4`, both reading continuously -> grant sequence A,A,A,A,B repeating; `wait_cnt` returns to 0 after each B grant.
- `CPU_PRIORITY=0`, both requesting continuously -> grants alternate A,B,A,B…; with only `b_req` high, B is granted every cycle.
- Preload 0x001=0x11111111 and 0x002=0x22222222; A reads 0x001 and B reads 0x002 in consecutive cycles -> `a_rvalid`/0x11111111, then next cycle `b_rvalid`/0x22222222, never crossed.
- Grant an A read, then pull `reset` low on the next edge -> no `a_rvalid` ever appears for that read; all outputs at reset values.
